// File: rtl/vx_issue_sched.sv
// Multi-channel issue scheduler: per-channel register scoreboard, round-robin pick of one
// hazard-free head per cycle, registered output slot towards dispatch, and perf counters.
module vx_issue_sched #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned NR_BITS       = 5,
  parameter int unsigned INSTR_W       = 64,
  parameter int unsigned PERF_CTR_BITS = 44,
  localparam int unsigned CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CHANNELS-1:0]         in_valid,
  output logic [NUM_CHANNELS-1:0]         in_ready,
  input  logic [NUM_CHANNELS-1:0]         in_wb,
  input  logic [NUM_CHANNELS*NR_BITS-1:0] in_rd,
  input  logic [NUM_CHANNELS*NR_BITS-1:0] in_rs1,
  input  logic [NUM_CHANNELS*NR_BITS-1:0] in_rs2,
  input  logic [NUM_CHANNELS*NR_BITS-1:0] in_rs3,
  input  logic [NUM_CHANNELS*INSTR_W-1:0] in_payload,
  input  logic                            wb_valid,
  input  logic [CH_BITS-1:0]              wb_wid,
  input  logic [NR_BITS-1:0]              wb_rd,
  input  logic                            wb_eop,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CH_BITS-1:0]              out_wid,
  output logic [INSTR_W-1:0]              out_payload,
  output logic [PERF_CTR_BITS-1:0]        perf_scb_stalls,
  output logic [PERF_CTR_BITS-1:0]        perf_disp_stalls,
  output logic [PERF_CTR_BITS-1:0]        perf_issued
);

  localparam int unsigned NREGS = 2 ** NR_BITS;
  localparam int unsigned IDX_W = CH_BITS + 1;

  logic [NR_BITS-1:0]       rd_a   [NUM_CHANNELS];
  logic [NR_BITS-1:0]       rs1_a  [NUM_CHANNELS];
  logic [NR_BITS-1:0]       rs2_a  [NUM_CHANNELS];
  logic [NR_BITS-1:0]       rs3_a  [NUM_CHANNELS];
  logic [INSTR_W-1:0]       pay_a  [NUM_CHANNELS];
  logic [NREGS-1:0]         pend_q [NUM_CHANNELS];
  logic [NREGS-1:0]         pend_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  elig;

  logic                     out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]       out_wid_q, out_wid_d;
  logic [INSTR_W-1:0]       out_payload_q, out_payload_d;
  logic [CH_BITS-1:0]       rr_q, rr_d;
  logic [PERF_CTR_BITS-1:0] scb_stalls_q, scb_stalls_d;
  logic [PERF_CTR_BITS-1:0] disp_stalls_q, disp_stalls_d;
  logic [PERF_CTR_BITS-1:0] issued_q, issued_d;

  logic                     can_load;
  logic                     grant_any;
  logic [CH_BITS-1:0]       grant_idx;
  logic [NUM_CHANNELS-1:0]  grant_c;
  logic [IDX_W-1:0]         scan;
  logic [IDX_W-1:0]         rr_inc;
  logic                     wb_in_range;

  // Unpack per-channel head fields; scoreboard lookups use registered state only.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign rd_a[i]  = in_rd[i*NR_BITS +: NR_BITS];
    assign rs1_a[i] = in_rs1[i*NR_BITS +: NR_BITS];
    assign rs2_a[i] = in_rs2[i*NR_BITS +: NR_BITS];
    assign rs3_a[i] = in_rs3[i*NR_BITS +: NR_BITS];
    assign pay_a[i] = in_payload[i*INSTR_W +: INSTR_W];
    assign elig[i]  = in_valid[i]
                      && !pend_q[i][rs1_a[i]]
                      && !pend_q[i][rs2_a[i]]
                      && !pend_q[i][rs3_a[i]]
                      && !(in_wb[i] && pend_q[i][rd_a[i]]);
  end

  assign can_load = !out_valid_q || out_ready;

  // Round-robin: first eligible channel at or after rr_q, wrapping.
  always_comb begin
    grant_c   = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    if (can_load) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        scan = {1'b0, rr_q} + IDX_W'(k);
        if (scan >= IDX_W'(NUM_CHANNELS)) begin
          scan = scan - IDX_W'(NUM_CHANNELS);
        end
        if (!grant_any && elig[scan[CH_BITS-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan[CH_BITS-1:0];
        end
      end
    end
    if (grant_any) begin
      grant_c[grant_idx] = 1'b1;
    end
  end

  assign in_ready = grant_c;

  assign rr_inc      = {1'b0, grant_idx} + IDX_W'(1);
  assign wb_in_range = ({1'b0, wb_wid} < IDX_W'(NUM_CHANNELS));

  // Output slot, pointer and counters.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_wid_d     = out_wid_q;
    out_payload_d = out_payload_q;
    rr_d          = rr_q;
    scb_stalls_d  = scb_stalls_q;
    disp_stalls_d = disp_stalls_q;
    issued_d      = issued_q;
    if (grant_any) begin
      out_valid_d   = 1'b1;
      out_wid_d     = grant_idx;
      out_payload_d = pay_a[grant_idx];
      rr_d          = (rr_inc >= IDX_W'(NUM_CHANNELS)) ? '0 : rr_inc[CH_BITS-1:0];
      issued_d      = issued_q + PERF_CTR_BITS'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (|in_valid && !(|elig)) begin
      scb_stalls_d = scb_stalls_q + PERF_CTR_BITS'(1);
    end
    if (out_valid_q && !out_ready) begin
      disp_stalls_d = disp_stalls_q + PERF_CTR_BITS'(1);
    end
  end

  // Scoreboard: eop writeback clears, a same-edge grant set wins; r0 never pends.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      pend_d[i] = pend_q[i];
    end
    if (wb_valid && wb_eop && wb_in_range) begin
      pend_d[wb_wid][wb_rd] = 1'b0;
    end
    if (grant_any && in_wb[grant_idx] && (rd_a[grant_idx] != '0)) begin
      pend_d[grant_idx][rd_a[grant_idx]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_wid_q     <= '0;
      out_payload_q <= '0;
      rr_q          <= '0;
      scb_stalls_q  <= '0;
      disp_stalls_q <= '0;
      issued_q      <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      out_valid_q   <= out_valid_d;
      out_wid_q     <= out_wid_d;
      out_payload_q <= out_payload_d;
      rr_q          <= rr_d;
      scb_stalls_q  <= scb_stalls_d;
      disp_stalls_q <= disp_stalls_d;
      issued_q      <= issued_d;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_wid          = out_wid_q;
  assign out_payload      = out_payload_q;
  assign perf_scb_stalls  = scb_stalls_q;
  assign perf_disp_stalls = disp_stalls_q;
  assign perf_issued      = issued_q;

  // Grant sanity, sampled on settled pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant_c));
      assert ((grant_c & ~elig) == '0);
    end
  end

endmodule
